// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int REGFILE_DATA_W   = 24;
  localparam int REGFILE_NUM_REGS = 16;

  // CLEAR is the reset state; IDLE is normal operation.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear engine: walks clr_idx from 1 to NUM_REGS-1, one register per cycle.
// Latency: busy is a registered state decode; wr_rdy is combinational.
// Backpressure: wr_rdy drops while clearing and in the cycle a clear is requested.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset (reset starts a clear)
//   clr_req   : one-cycle clear request, honoured only in IDLE
//   clr_last  : clr_idx currently addresses the highest register
//   state     : current FSM state
//   clr_idx   : register being zeroed this cycle while in CLEAR
//   busy      : high while in CLEAR
//   wr_rdy    : writes are accepted this cycle
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic              clr_last,
  output rf_state_t         state,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              busy,
  output logic              wr_rdy
);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    case (state_q)
      CLEAR: begin
        // clr_req is ignored here: an in-progress clear never restarts.
        if (clr_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          clr_idx_d = clr_idx_q + ADDR_W'(1);
        end
      end
      default: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = ADDR_W'(1);
          busy_d    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= ADDR_W'(1);
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  assign state   = state_q;
  assign clr_idx = clr_idx_q;
  assign busy    = busy_q;
  // A clear request in the same cycle as a write wins over the write.
  assign wr_rdy  = (state_q == IDLE) && !clr_req;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file, 1 write port and NUM_RD combinational read ports, R0 = 0.
// Latency: reads zero-cycle; writes visible next cycle (same cycle with REGFILE_BYPASS_EN).
// Backpressure: wr_rdy low while the clear engine runs or a clear is requested; dropped writes are lost.
//
// Optional feature macro: REGFILE_BYPASS_EN (accepted write data forwarded to matching read ports).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset (reset clears the array)
//   clr_req           : one-cycle request to zero all registers
//   busy              : clear engine running; all reads return 0
//   wr_rdy            : write accepted this cycle
//   wr_en/addr/data   : write port; address 0 and out-of-range addresses are discarded
//   rd_addr / rd_data : packed read ports, port k at [k*ADDR_W +: ADDR_W] / [k*DATA_W +: DATA_W]
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     wr_rdy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  rf_state_t         state;
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_last;
  logic              wr_in_range;
  logic              wr_fire;

  // R0 has no storage.
  logic [DATA_W-1:0] mem_q [1:NUM_REGS-1];
  logic [DATA_W-1:0] mem_d [1:NUM_REGS-1];

  assign clr_last = (clr_idx == ADDR_W'(NUM_REGS - 1));

  regfile_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_last (clr_last),
    .state    (state),
    .clr_idx  (clr_idx),
    .busy     (busy),
    .wr_rdy   (wr_rdy)
  );

  // One extra bit so the compare stays meaningful when NUM_REGS is a power of two.
  assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W + 1)'(NUM_REGS));
  assign wr_fire     = wr_en && wr_rdy && (wr_addr != '0) && wr_in_range;

  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
      if ((state == CLEAR) && (clr_idx == ADDR_W'(i))) begin
        mem_d[i] = '0;
      end else if (wr_fire && (wr_addr == ADDR_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  // Contents are not reset: the clear engine zeroes them after reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      // Address 0 and out-of-range addresses match no entry and read 0.
      rv = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (ra == ADDR_W'(i)) rv = mem_q[i];
      end
`ifdef REGFILE_BYPASS_EN
      // wr_fire already excludes R0, out-of-range and busy.
      if (wr_fire && (ra == wr_addr)) rv = wr_data;
`endif
      // The array is logically zero for the whole clear.
      if (busy) rv = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = rv;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the CPU's 2-read/1-write register file.
- Configurable data width, register count and number of read ports.
- R0 is hardwired to zero.
- Adds synchronous reset, a sequential clear engine (one register per cycle, with a busy/ready handshake) and optional write-to-read bypass.
- Sits between decode (read ports) and writeback (write port) in the CPU datapath.

Parameters:
- DATA_W, 24, register width in bits.
- NUM_REGS, 16, number of registers including R0; legal range is 2 to 256.
- ADDR_W, $clog2(NUM_REGS), address width.
- NUM_RD, 2, number of combinational read ports; legal range is 1 to 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  one-cycle request to zero all registers.
- busy  out  1  high while the clear engine runs.
- wr_rdy  out  1  write accepted this cycle; equals (state==IDLE) && !clr_req.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].

Behaviour:
- Storage: NUM_REGS-1 registers (R1..NUM_REGS-1), each DATA_W bits. R0 has no storage.
- FSM states: CLEAR and IDLE.
- Reset: rst=1 at a clk edge forces state=CLEAR, clr_idx=1 and busy=1. Register contents are don't-care; the clear engine zeroes them. No initial blocks are relied on.
- CLEAR state:
  - Each cycle writes 0 to R[clr_idx], then clr_idx increments.
  - When clr_idx==NUM_REGS-1 is written, the next state is IDLE and busy=0.
  - Duration is exactly NUM_REGS-1 cycles. With NUM_REGS=2 this is 1 cycle.
  - clr_req is ignored; the clear does not restart.
  - wr_rdy=0 and writes are dropped.
  - All read ports return 0. The array is logically zero from the cycle the clear is entered.
- IDLE state:
  - clr_req=1 moves to CLEAR with clr_idx=1 on the next edge, and busy rises that edge.
  - If clr_req=1 and wr_en=1 in the same cycle, the clear wins, wr_rdy=0 and the write is dropped.
- Write: when wr_en && wr_rdy && wr_addr!=0 && wr_addr<NUM_REGS, R[wr_addr] takes wr_data at the edge. Writes to address 0 or an out-of-range address are silently discarded.
- Read (combinational, zero latency):
  - rd_data[k] = 0 if rd_addr[k]==0, or rd_addr[k]>=NUM_REGS, or busy.
  - Otherwise rd_data[k] = R[rd_addr[k]], subject to bypass (see Optional Feature).
  - All ports are independent; any number may read the same address.
- Reset mid-clear: rst restarts the clear from clr_idx=1.
- Reset in IDLE: same as power-on; enters CLEAR.
- No other outputs are registered. busy is a registered state decode.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When a write is accepted this cycle (wr_en && wr_rdy && wr_addr!=0 && in range), any port with rd_addr[k]==wr_addr returns wr_data combinationally in the same cycle.
  - The bypass applies to all NUM_RD ports.
  - Never applies to R0 or while busy.
- Undefined: reads return the stored value only, so a same-cycle read sees the old value and the new value is visible the cycle after the write edge.

Decomposition:
- Package regfile_pkg holds:
  - Default constants REGFILE_DATA_W=24 and REGFILE_NUM_REGS=16.
  - typedef enum logic [0:0] {IDLE, CLEAR} rf_state_t.
- One sub-module, regfile_clr_fsm, owns:
  - Inputs: clk, rst, clr_req, last-index compare.
  - Outputs: state, clr_idx, busy, wr_rdy.
- The array, write mux and read/bypass logic live in regfile_mp. A generate loop instantiates the NUM_RD read ports.

Test Plan:
- Reset clear timing: pulse rst 1 cycle, NUM_REGS=16 → busy=1 for exactly 15 cycles, then 0; every rd_data=0 throughout; wr_en with wr_addr=5 during the clear has wr_rdy=0 and R5 still reads 0 afterwards.
- R0 and range guards: write 24'hABCDEF to addr 0 → port 0 reads 0 on addr 0. NUM_REGS=12, write to addr 13 → no register changes.
- Basic write/read: write 24'h000123 to R3 → next cycle all ports reading addr 3 return 24'h000123; other registers stay 0.
- Bypass: write 24'h00BEEF to R7 while port 1 reads addr 7 in the same cycle.
  - With REGFILE_BYPASS_EN: rd_data[1]=24'h00BEEF that cycle.
  - Without it: old value (0) that cycle and 24'h00BEEF the next cycle.
- Clear vs write collision: in IDLE with R2=24'h000055, assert clr_req and wr_en (addr 2, data 24'h0000AA) together → wr_rdy=0, busy=1 next edge, R2 reads 0 after the clear, never 24'h0000AA.
- Reset mid-clear: assert rst 5 cycles into a clear → busy stays 1 and the clear ends 15 cycles after rst deasserts; a clr_req pulsed during CLEAR does not extend it.
